// File: rtl/cache_miss_handler.sv
// Cache miss handler: arbitrates I-/D-cache misses (D first), streams one
// block from a pipelined main memory and writes it into the owning cache.
// A word is written on every memory-valid cycle; the tag is written with
// the last word. One DONE cycle follows for the cache re-lookup.
module cache_miss_handler #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_data_valid,
  output logic [15:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic        i_write_data,
  output logic        i_write_tag,
  output logic        d_write_data,
  output logic        d_write_tag,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        i_stall,
  output logic        d_stall,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Block size in bytes is 2*BLOCK_WORDS; the mask clears the in-block offset.
  localparam logic [15:0] BLK_MASK  = ~(16'(BLOCK_WORDS * 2) - 16'd1);
  localparam logic [3:0]  ISSUE_MAX = 4'(BLOCK_WORDS);
  localparam logic [2:0]  RECV_LAST = 3'(BLOCK_WORDS - 1);

  // Owner encoding: 1 = D-cache, 0 = I-cache.
  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;

  logic        fill_wr;
  logic        last_word;
  logic        issuing;

  // Next-state: grant in IDLE, issue/receive in FILL, single-cycle DONE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (d_miss) begin
          state_d     = ST_FILL;
          owner_d     = 1'b1;
          base_d      = d_miss_addr & BLK_MASK;
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 3'd0;
        end else if (i_miss) begin
          state_d     = ST_FILL;
          owner_d     = 1'b0;
          base_d      = i_miss_addr & BLK_MASK;
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 3'd0;
        end
      end
      ST_FILL: begin
        // Requests go out back to back; the counter parks at BLOCK_WORDS.
        if (issue_cnt_q < ISSUE_MAX) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        // Only returned words advance the fill, so latency and gaps are free.
        if (mem_data_valid) begin
          recv_cnt_d = recv_cnt_q + 3'd1;
          if (recv_cnt_q == RECV_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any fill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      base_q      <= 16'd0;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Memory request and cache write outputs, all decoded from current state.
  always_comb begin
    issuing   = (state_q == ST_FILL) && (issue_cnt_q < ISSUE_MAX);
    fill_wr   = (state_q == ST_FILL) && mem_data_valid;
    last_word = fill_wr && (recv_cnt_q == RECV_LAST);

    mem_wr     = 1'b0;
    mem_enable = issuing;
    mem_addr   = issuing ? (base_q + {11'd0, issue_cnt_q, 1'b0}) : 16'd0;

    d_write_data = fill_wr && owner_q;
    i_write_data = fill_wr && !owner_q;
    d_write_tag  = last_word && owner_q;
    i_write_tag  = last_word && !owner_q;

    fill_word = fill_wr ? recv_cnt_q : 3'd0;
    fill_data = fill_wr ? mem_data : 16'd0;
  end

  // Stalls: own miss input, or ownership of a fill in progress. Gated by
  // rst_n so every output reads zero while reset is held.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    i_stall = rst_n && (i_miss || (!owner_q && busy));
    d_stall = rst_n && (d_miss || (owner_q && busy));
  end

endmodule

// File: doc/cache_miss_handler.md
CACHE_MISS_HANDLER -- requirements
Module: cache_miss_handler

Interface
REQ-001 BLOCK_WORDS, 8, 16-bit words per cache block; power of two, at most 8.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_miss, i_miss_addr  input  1, 16  I-cache miss request and byte address.
REQ-005 d_miss, d_miss_addr  input  1, 16  D-cache miss request and byte address.
REQ-006 mem_data, mem_data_valid  input  16, 1  main-memory read data and its valid strobe.
REQ-007 mem_addr, mem_enable, mem_wr  output  16, 1, 1  main-memory request; mem_wr is constant 0.
REQ-008 i_write_data, i_write_tag  output  1, 1  I-cache data-array and tag-array write enables.
REQ-009 d_write_data, d_write_tag  output  1, 1  D-cache data-array and tag-array write enables.
REQ-010 fill_word, fill_data  output  3, 16  word index and data for the active cache write.
REQ-011 i_stall, d_stall, busy  output  1 each  pipeline stalls; busy means state is not IDLE.

Function
REQ-012 States SHALL be IDLE, FILL and DONE, stored in registers.
REQ-013 In IDLE with d_miss=1, the block SHALL move to FILL with owner=D, whatever the value of i_miss (D has priority).
REQ-014 In IDLE with d_miss=0 and i_miss=1, the block SHALL move to FILL with owner=I.
REQ-015 On grant, the block SHALL latch base = owner address with bits [3:0] cleared (block-aligned); the miss inputs SHALL be ignored outside IDLE.
REQ-016 In FILL, a 4-bit issue counter (0..BLOCK_WORDS) SHALL drive mem_addr = base + 2*issue_cnt and mem_enable=1 while issue_cnt < BLOCK_WORDS.
REQ-017 issue_cnt SHALL increment once per cycle and saturate at BLOCK_WORDS, at which point mem_enable=0 and mem_addr=0.
REQ-018 In FILL, each mem_data_valid=1 cycle SHALL assert the owner's write_data for that cycle, with fill_word=recv_cnt and fill_data=mem_data combinationally; recv_cnt then increments.
REQ-019 The block SHALL tolerate any memory latency and any gaps in mem_data_valid; only valid cycles advance recv_cnt.
REQ-020 On the valid cycle with recv_cnt = BLOCK_WORDS-1, the owner's write_tag SHALL also be 1 and the next state SHALL be DONE.
REQ-021 DONE SHALL last exactly one cycle (cache re-lookup slot), then return to IDLE; a miss pending at that point is granted per REQ-013/014.
REQ-022 x_stall SHALL be 1 when x_miss=1, or when owner=x and state is not IDLE; the non-owner stalls only through its own miss input.
REQ-023 mem_data_valid in IDLE or DONE SHALL be ignored, with no cache writes.
REQ-024 Write enables for the non-owner cache SHALL never assert.
REQ-025 fill_word and fill_data SHALL be 0 in any cycle with no data write.
REQ-026 recv_cnt and issue_cnt SHALL clear on every grant.

Reset
REQ-027 While rst_n=0, the state SHALL be IDLE, owner, base and counters SHALL be 0, and all outputs SHALL be 0 immediately, without waiting for clk.
REQ-028 Reset mid-FILL SHALL abandon the fill: no tag write is issued, and later stray mem_data_valid is ignored per REQ-023.
REQ-029 After reset release, the first grant SHALL occur on the first rising edge that sees a miss.

Verification
REQ-030 Setup: all scenarios use a 4-cycle-latency, pipelined memory model.
REQ-031 d_miss, addr 0x1236 -> mem_addr 0x1230..0x123E on 8 consecutive cycles; d_write_data on 8 cycles with fill_word 0..7; d_write_tag with word 7; DONE; IDLE.
REQ-032 i_miss and d_miss asserted in the same cycle -> D fill at the D base runs first, with i_stall held throughout; I fill is granted on the edge after DONE.
REQ-033 Memory with valid gaps (valid every other cycle) -> exactly 8 writes, fill_word strictly 0..7, tag write only on the eighth.
REQ-034 rst_n low during 5th returned word -> outputs 0 asynchronously; post-reset valid pulses produce no writes; a new i_miss 0x00A0 fills 0x00A0..0x00AE cleanly.
REQ-035 mem_data_valid pulsed in IDLE -> no write enables and no state change; i_miss alone with addr 0xFFFE -> base 0xFFF0, last address 0xFFFE, no wrap past 0xFFFE.
